// File: rtl/lock_keypad_conditioner.sv
// lock_keypad_conditioner: synchronise and debounce the enter button and digit switches,
// emitting one enter_pulse (or reject_pulse) per clean press.
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   enter_btn_raw  in   raw bouncy enter button, active-high
//   digit_raw      in   raw 4-bit digit switches
//   digit_out      out  digit captured at the last accepted press
//   enter_pulse    out  one-cycle strobe, press accepted, digit_out valid same cycle
//   reject_pulse   out  one-cycle strobe, press discarded because the digit moved
//   btn_held       out  high while the press is held or its release is debouncing
module lock_keypad_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter_btn_raw,
    input  logic [3:0] digit_raw,
    output logic [3:0] digit_out,
    output logic       enter_pulse,
    output logic       reject_pulse,
    output logic       btn_held
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    logic [SYNC_STAGES-1:0]      btn_sync;
    logic [SYNC_STAGES-1:0][3:0] dig_sync;
    logic                        btn_s;
    logic [3:0]                  dig_s;
    logic [1:0]                  state;
    logic [CNT_W-1:0]            cnt;
    logic [3:0]                  dig_ref;

    assign btn_s    = btn_sync[SYNC_STAGES-1];
    assign dig_s    = dig_sync[SYNC_STAGES-1];
    assign btn_held = (state == HELD) || (state == RELEASE_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
            dig_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], enter_btn_raw};
            dig_sync <= {dig_sync[SYNC_STAGES-2:0], digit_raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            dig_ref      <= 4'h0;
            digit_out    <= 4'h0;
            enter_pulse  <= 1'b0;
            reject_pulse <= 1'b0;
        end else begin
            enter_pulse  <= 1'b0;
            reject_pulse <= 1'b0;
            case (state)
                IDLE: if (btn_s) begin
                    state   <= PRESS_WAIT;
                    cnt     <= '0;
                    dig_ref <= dig_s;
                end
                // Bounce beats digit change, and digit change beats acceptance.
                PRESS_WAIT: if (!btn_s) begin
                    state <= IDLE;
                end else if (dig_s != dig_ref) begin
                    state        <= HELD;
                    reject_pulse <= 1'b1;
                end else if (cnt == LAST) begin
                    state       <= HELD;
                    enter_pulse <= 1'b1;
                    digit_out   <= dig_ref;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                HELD: if (!btn_s) begin
                    state <= RELEASE_WAIT;
                    cnt   <= '0;
                end
                RELEASE_WAIT: if (btn_s) begin
                    state <= HELD;
                end else if (cnt == LAST) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lock_keypad_conditioner.sv
// tb_lock_keypad_conditioner: scoreboard bench for the default build and a DEBOUNCE_CYCLES=1 build.
module tb_lock_keypad_conditioner;
    typedef struct packed {
        logic       en;
        logic [3:0] dig;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn = 1'b0;
    logic [3:0] dig = 4'h0;
    logic [3:0] digit_out;
    logic       enter_pulse, reject_pulse, btn_held;
    logic       b_btn = 1'b0;
    logic [3:0] b_dig = 4'h0;
    logic [3:0] b_digit_out;
    logic       b_enter, b_reject, b_held;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    ev_t        q0[$];
    ev_t        q1[$];

    lock_keypad_conditioner u0 (
        .clk(clk), .rst_n(rst_n), .enter_btn_raw(btn), .digit_raw(dig),
        .digit_out(digit_out), .enter_pulse(enter_pulse),
        .reject_pulse(reject_pulse), .btn_held(btn_held)
    );

    lock_keypad_conditioner #(.DEBOUNCE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enter_btn_raw(b_btn), .digit_raw(b_dig),
        .digit_out(b_digit_out), .enter_pulse(b_enter),
        .reject_pulse(b_reject), .btn_held(b_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (enter_pulse || reject_pulse)) begin
            check("excl", int'(enter_pulse & reject_pulse), 0);
            check("pending", int'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("kind", int'(enter_pulse), int'(e.en));
                check("digit", int'(digit_out), int'(e.dig));
                check("when", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (rst_n && (b_enter || b_reject)) begin
            check("d1_excl", int'(b_enter & b_reject), 0);
            check("d1_pending", int'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("d1_kind", int'(b_enter), int'(e.en));
                check("d1_digit", int'(b_digit_out), int'(e.dig));
                check("d1_when", cyc, e.cyc);
            end
        end
    end

    initial begin
        tick(3);
        check("rst_digit", int'(digit_out), 0);
        check("rst_enter", int'(enter_pulse), 0);
        check("rst_reject", int'(reject_pulse), 0);
        check("rst_held", int'(btn_held), 0);
        rst_n = 1'b1;
        tick(5);
        // clean press of 7, held 40 cycles
        dig = 4'h7;
        btn = 1'b1;
        q0.push_back('{1'b1, 4'h7, cyc + 19});
        tick(40);
        check("t1_held", int'(btn_held), 1);
        check("t1_digit", int'(digit_out), 7);
        btn = 1'b0;
        tick(18);
        check("t1_held_late", int'(btn_held), 1);
        tick(1);
        check("t1_released", int'(btn_held), 0);
        tick(5);
        // bouncing press, then stable
        dig = 4'h2;
        for (int i = 0; i < 2; i++) begin
            btn = 1'b1;
            tick(3);
            btn = 1'b0;
            tick(3);
        end
        btn = 1'b1;
        q0.push_back('{1'b1, 4'h2, cyc + 19});
        tick(30);
        btn = 1'b0;
        tick(25);
        // digit moves 3 -> 5 during debounce
        dig = 4'h3;
        tick(3);
        btn = 1'b1;
        tick(8);
        dig = 4'h5;
        q0.push_back('{1'b0, 4'h2, cyc + 3});
        tick(30);
        check("t3_digit_kept", int'(digit_out), 2);
        btn = 1'b0;
        tick(25);
        // two presses with a 20-cycle release
        dig = 4'h1;
        tick(3);
        btn = 1'b1;
        q0.push_back('{1'b1, 4'h1, cyc + 19});
        tick(30);
        check("t4_digit1", int'(digit_out), 1);
        btn = 1'b0;
        tick(20);
        dig = 4'h9;
        btn = 1'b1;
        q0.push_back('{1'b1, 4'h9, cyc + 19});
        tick(30);
        check("t4_digit9", int'(digit_out), 9);
        // 5-cycle release is still a bounce: no new press
        btn = 1'b0;
        dig = 4'h6;
        tick(5);
        btn = 1'b1;
        tick(30);
        check("t4_short_digit", int'(digit_out), 9);
        check("t4_short_held", int'(btn_held), 1);
        btn = 1'b0;
        tick(25);
        // reset mid-debounce, button stays high
        dig = 4'h4;
        tick(3);
        btn = 1'b1;
        tick(10);
        rst_n = 1'b0;
        #1;
        check("t5_digit", int'(digit_out), 0);
        check("t5_enter", int'(enter_pulse), 0);
        check("t5_reject", int'(reject_pulse), 0);
        check("t5_held", int'(btn_held), 0);
        tick(3);
        rst_n = 1'b1;
        q0.push_back('{1'b1, 4'h4, cyc + 19});
        tick(30);
        check("t5_digit_after", int'(digit_out), 4);
        btn = 1'b0;
        tick(25);
        // single-cycle debounce build
        b_dig = 4'h6;
        tick(3);
        b_btn = 1'b1;
        q1.push_back('{1'b1, 4'h6, cyc + 4});
        tick(30);
        check("t6_held", int'(b_held), 1);
        b_btn = 1'b0;
        tick(10);
        check("t6_released", int'(b_held), 0);
        b_dig = 4'h3;
        b_btn = 1'b1;
        q1.push_back('{1'b1, 4'h3, cyc + 4});
        tick(20);
        check("t6_digit", int'(b_digit_out), 3);
        b_btn = 1'b0;
        tick(10);
        check("leftover", q0.size(), 0);
        check("d1_leftover", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
